if_fetch_stage: RTL and testbench
=================================

# if_fetch_stage

Instruction-fetch stage of the five-stage pipelined CPU, directly upstream of the decode/register-read stage. Owns the program counter and drives the instruction-memory address. Captures the fetched word into the IF/ID pipeline register. Honours stall requests from the hazard unit and redirects on branches resolved in EX, squashing wrong-path instructions with bubbles.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000, PC loaded on reset; must be word-aligned.
- CNT_W, 32, width of the performance counters (only with IF_PERF_CNT_EN).

Ports:
- clk  in  1  pipeline clock; all state updates on its falling edge, like every other pipeline register.
- reset  in  1  synchronous, active-high.
- stall  in  1  hazard unit: hold PC and IF/ID.
- br_taken  in  1  EX-stage branch decision (nPC_sel).
- br_pc4  in  32  PC+4 of the branch instruction, carried to EX.
- br_imm16  in  16  branch offset field of the branch instruction.
- imem_addr  out  32  instruction-memory read address, equal to current PC.
- imem_data  in  32  combinational read data for imem_addr.
- if_id_inst  out  32  IF/ID instruction register.
- if_id_pc4  out  32  IF/ID PC+4.
- if_id_valid  out  1  IF/ID holds a real instruction.
- id_flush  out  1  combinational; squash the instruction currently in ID.
- fetch_cnt, bubble_cnt  out  CNT_W  only with IF_PERF_CNT_EN.

## Operation
- FSM states: BOOT, RUN, STALL, REDIRECT.
- BOOT: entered on reset. Next edge moves to RUN without capturing; if_id_valid stays 0.
- RUN: each edge does pc <= pc+4, if_id_inst <= imem_data, if_id_pc4 <= pc+4, if_id_valid <= 1.
- stall=1 in RUN: go to STALL; PC and IF/ID are held unchanged.
- STALL: stays while stall=1; returns to RUN and fetches normally when stall=0.
- br_taken=1 in RUN or STALL:
  - pc <= target, where target = br_pc4 + {{14{br_imm16[15]}}, br_imm16, 2'b00}, modulo 2^32.
  - if_id_inst <= 32'h0000_0000 (NOP), if_id_valid <= 0.
  - Go to REDIRECT.
- id_flush = br_taken, combinationally, in every state except BOOT.
- REDIRECT: one cycle that fetches from the target and captures normally. Then RUN, or STALL if stall=1.
- Priority: reset > br_taken > stall.
- Wrap-around: PC 32'hFFFF_FFFC increments to 32'h0000_0000, with no flag.
- br_taken during BOOT is ignored.

## Timing
- Reset values:
  - pc = RESET_PC, so imem_addr = RESET_PC.
  - if_id_inst = 0, if_id_pc4 = 0, if_id_valid = 0, id_flush = 0.
  - Counters = 0; state = BOOT.
- Fetch latency: an instruction at PC appears on if_id_inst one falling edge after PC is presented, provided stall=0.
- Branch penalty: 2 bubbles, one squashed in IF/ID and one squashed in ID via id_flush.
- The first target instruction reaches if_id_inst 2 edges after br_taken is sampled.
- Reset asserted mid-stall or mid-redirect takes effect at the next edge, regardless of other inputs.

## Configuration
- IF_PERF_CNT_EN defined:
  - fetch_cnt increments on each edge that sets if_id_valid=1.
  - bubble_cnt increments on each edge where a NOP is inserted or a stall holds.
  - Both counters wrap at 2^CNT_W and clear on reset.
- IF_PERF_CNT_EN undefined: the counter ports and logic are absent.

## Structure
- Shared header cpu_defs.vh holds the NOP encoding (32'h0), the FSM state encodings and the default RESET_PC.
- One sub-module, branch_target: sign-extend, shift left by 2, and 32-bit add. It is purely combinational and can be reused by the EX stage.

## Test plan
- Reset, then 4 edges with no stall or branch: imem_addr goes 0, 4, 8, 12; if_id_pc4 is 4, 8, 12; if_id_valid rises on the 2nd edge.
- stall=1 for 3 edges at pc=0x10: pc stays 0x10, if_id_inst is unchanged; release resumes fetching at 0x10.
- br_taken with br_pc4=0x20 and br_imm16=16'hFFFE: pc=0x18, id_flush=1 that cycle, if_id_inst=0 and valid=0; the target instruction appears 2 edges later.
- br_taken and stall together: the branch wins, pc=target and the stall is ignored for that edge.
- pc=0xFFFF_FFFC with no stall: the next pc is 0x0000_0000.
- IF_PERF_CNT_EN defined, 10 edges containing 1 branch and 2 stall edges: fetch_cnt=6, bubble_cnt=3.

Source files
------------

// File: rtl/if_fetch_stage_pkg.sv
// Shared definitions for the instruction-fetch stage: NOP encoding, FSM states,
// default reset PC and the branch-offset helper.
package if_fetch_stage_pkg;

    localparam logic [31:0] NOP_INST         = 32'h0000_0000;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    typedef enum logic [1:0] {
        ST_BOOT     = 2'd0,
        ST_RUN      = 2'd1,
        ST_STALL    = 2'd2,
        ST_REDIRECT = 2'd3
    } fetch_state_e;

    // Branch offsets count words, so the 16-bit field becomes a signed byte offset.
    function automatic logic [31:0] branch_byte_offset(input logic [15:0] imm16);
        return {{14{imm16[15]}}, imm16, 2'b00};
    endfunction

endpackage

// File: rtl/if_fetch_stage_branch_target.sv
// Branch target adder: sign-extend, shift by 2, add to PC+4 (mod 2^32).
// Purely combinational so the EX stage can reuse it.
module branch_target
    import if_fetch_stage_pkg::*;
(
    input  logic [31:0] pc4,
    input  logic [15:0] imm16,
    output logic [31:0] target
);

    assign target = pc4 + branch_byte_offset(imm16);

endmodule

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: owns the PC, drives imem, fills the IF/ID register.
// Optional performance counters are built only when IF_PERF_CNT_EN is defined.
module if_fetch_stage
    import if_fetch_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
    parameter int          CNT_W    = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              stall,
    input  logic              br_taken,
    input  logic [31:0]       br_pc4,
    input  logic [15:0]       br_imm16,
    output logic [31:0]       imem_addr,
    input  logic [31:0]       imem_data,
    output logic [31:0]       if_id_inst,
    output logic [31:0]       if_id_pc4,
    output logic              if_id_valid,
    output logic              id_flush
`ifdef IF_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0]  fetch_cnt,
    output logic [CNT_W-1:0]  bubble_cnt
`endif
);

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  if_id_inst_q, if_id_inst_d;
    logic [31:0]  if_id_pc4_q, if_id_pc4_d;
    logic         if_id_valid_q, if_id_valid_d;
    logic [31:0]  pc_plus4;
    logic [31:0]  br_target;
    logic         capture;
    logic         bubble;

    branch_target u_branch_target (
        .pc4    (br_pc4),
        .imm16  (br_imm16),
        .target (br_target)
    );

    assign pc_plus4 = pc_q + 32'd4;

    // NOTE: every signal gets a default before the case so no path leaves it
    // unassigned; that is what keeps this block free of inferred latches.
    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        if_id_inst_d  = if_id_inst_q;
        if_id_pc4_d   = if_id_pc4_q;
        if_id_valid_d = if_id_valid_q;
        capture       = 1'b0;
        bubble        = 1'b0;

        unique case (state_q)
            ST_BOOT: begin
                state_d = ST_RUN;
            end
            ST_RUN, ST_STALL: begin
                if (br_taken) begin
                    pc_d          = br_target;
                    if_id_inst_d  = NOP_INST;
                    if_id_valid_d = 1'b0;
                    bubble        = 1'b1;
                    state_d       = ST_REDIRECT;
                end else if (stall) begin
                    bubble  = 1'b1;
                    state_d = ST_STALL;
                end else begin
                    capture = 1'b1;
                    state_d = ST_RUN;
                end
            end
            ST_REDIRECT: begin
                capture = 1'b1;
                state_d = stall ? ST_STALL : ST_RUN;
            end
            default: begin
                state_d = ST_BOOT;
            end
        endcase

        if (capture) begin
            pc_d          = pc_plus4;
            if_id_inst_d  = imem_data;
            if_id_pc4_d   = pc_plus4;
            if_id_valid_d = 1'b1;
        end
    end

    // Pipeline registers update on the falling edge, matching the rest of the core.
    // NOTE: state is written with non-blocking assignments so every flop samples
    // pre-edge values, independent of statement order.
    always_ff @(negedge clk) begin
        if (reset) begin
            state_q       <= ST_BOOT;
            pc_q          <= RESET_PC;
            if_id_inst_q  <= NOP_INST;
            if_id_pc4_q   <= 32'h0000_0000;
            if_id_valid_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            if_id_inst_q  <= if_id_inst_d;
            if_id_pc4_q   <= if_id_pc4_d;
            if_id_valid_q <= if_id_valid_d;
        end
    end

    assign imem_addr   = pc_q;
    assign if_id_inst  = if_id_inst_q;
    assign if_id_pc4   = if_id_pc4_q;
    assign if_id_valid = if_id_valid_q;
    assign id_flush    = br_taken && (state_q != ST_BOOT);

`ifdef IF_PERF_CNT_EN
    logic [CNT_W-1:0] fetch_cnt_q, fetch_cnt_d;
    logic [CNT_W-1:0] bubble_cnt_q, bubble_cnt_d;

    always_comb begin
        fetch_cnt_d  = fetch_cnt_q + {{(CNT_W-1){1'b0}}, capture};
        bubble_cnt_d = bubble_cnt_q + {{(CNT_W-1){1'b0}}, bubble};
    end

    always_ff @(negedge clk) begin
        if (reset) begin
            fetch_cnt_q  <= '0;
            bubble_cnt_q <= '0;
        end else begin
            fetch_cnt_q  <= fetch_cnt_d;
            bubble_cnt_q <= bubble_cnt_d;
        end
    end

    assign fetch_cnt  = fetch_cnt_q;
    assign bubble_cnt = bubble_cnt_q;
`endif

endmodule

// File: tb/tb_if_fetch_stage.sv
// Directed bench for if_fetch_stage; counter checks are built with IF_PERF_CNT_EN.
module tb_if_fetch_stage;

    logic        clk;
    logic        reset;
    logic        stall;
    logic        br_taken;
    logic [31:0] br_pc4;
    logic [15:0] br_imm16;
    logic [31:0] imem_addr;
    logic [31:0] imem_data;
    logic [31:0] if_id_inst;
    logic [31:0] if_id_pc4;
    logic        if_id_valid;
    logic        id_flush;
`ifdef IF_PERF_CNT_EN
    logic [31:0] fetch_cnt;
    logic [31:0] bubble_cnt;
`endif

    int total = 0;
    int bad   = 0;

    if_fetch_stage #(
        .RESET_PC (32'h0000_0000),
        .CNT_W    (32)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .stall       (stall),
        .br_taken    (br_taken),
        .br_pc4      (br_pc4),
        .br_imm16    (br_imm16),
        .imem_addr   (imem_addr),
        .imem_data   (imem_data),
        .if_id_inst  (if_id_inst),
        .if_id_pc4   (if_id_pc4),
        .if_id_valid (if_id_valid),
        .id_flush    (id_flush)
`ifdef IF_PERF_CNT_EN
        ,
        .fetch_cnt   (fetch_cnt),
        .bubble_cnt  (bubble_cnt)
`endif
    );

    // Instruction memory contents: a fixed scramble of the address.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'hA5A5_0000;
    endfunction

    assign imem_data = mem_word(imem_addr);

    initial clk = 1'b1;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance one falling (active) edge and settle past it.
    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    initial begin
        reset    = 1'b1;
        stall    = 1'b0;
        br_taken = 1'b0;
        br_pc4   = 32'h0;
        br_imm16 = 16'h0;
        tick();
        tick();
        reset = 1'b0;
        #1;
        check("rst_addr",  imem_addr,   32'h0);
        check("rst_inst",  if_id_inst,  32'h0);
        check("rst_pc4",   if_id_pc4,   32'h0);
        check("rst_valid", {31'b0, if_id_valid}, 32'h0);
        check("rst_flush", {31'b0, id_flush},    32'h0);
`ifdef IF_PERF_CNT_EN
        check("rst_fcnt", fetch_cnt,  32'h0);
        check("rst_bcnt", bubble_cnt, 32'h0);
`endif
        br_taken = 1'b1;
        br_pc4   = 32'h0000_0100;
        #1;
        check("boot_flush", {31'b0, id_flush}, 32'h0);

        // BOOT edge: branch ignored, nothing captured
        tick();
        check("boot_addr",  imem_addr, 32'h0);
        check("boot_valid", {31'b0, if_id_valid}, 32'h0);
        br_taken = 1'b0;

        tick();
        check("run1_addr",  imem_addr,  32'h4);
        check("run1_pc4",   if_id_pc4,  32'h4);
        check("run1_inst",  if_id_inst, mem_word(32'h0));
        check("run1_valid", {31'b0, if_id_valid}, 32'h1);
        tick();
        check("run2_addr", imem_addr,  32'h8);
        check("run2_pc4",  if_id_pc4,  32'h8);
        check("run2_inst", if_id_inst, mem_word(32'h4));
        tick();
        check("run3_addr", imem_addr, 32'hC);
        check("run3_pc4",  if_id_pc4, 32'hC);
        tick();
        check("run4_addr", imem_addr,  32'h10);
        check("run4_inst", if_id_inst, mem_word(32'hC));

        // three stall edges at pc=0x10
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("stall_addr",  imem_addr,  32'h10);
            check("stall_inst",  if_id_inst, mem_word(32'hC));
            check("stall_valid", {31'b0, if_id_valid}, 32'h1);
        end
        stall = 1'b0;
        tick();
        check("resume_addr", imem_addr,  32'h14);
        check("resume_inst", if_id_inst, mem_word(32'h10));
        check("resume_pc4",  if_id_pc4,  32'h14);

        // backward branch: 0x20 + (-2 << 2) = 0x18
        br_taken = 1'b1;
        br_pc4   = 32'h0000_0020;
        br_imm16 = 16'hFFFE;
        #1;
        check("br_flush", {31'b0, id_flush}, 32'h1);
        tick();
        check("br_addr",  imem_addr,  32'h18);
        check("br_inst",  if_id_inst, 32'h0);
        check("br_valid", {31'b0, if_id_valid}, 32'h0);
        br_taken = 1'b0;
        #1;
        check("br_flush_clr", {31'b0, id_flush}, 32'h0);
        tick();
        check("redir_addr",  imem_addr,  32'h1C);
        check("redir_inst",  if_id_inst, mem_word(32'h18));
        check("redir_pc4",   if_id_pc4,  32'h1C);
        check("redir_valid", {31'b0, if_id_valid}, 32'h1);
        tick();
        check("post_addr", imem_addr,  32'h20);
        check("post_inst", if_id_inst, mem_word(32'h1C));

        // branch and stall together: 0x100 + (0x10 << 2) = 0x140
        br_taken = 1'b1;
        stall    = 1'b1;
        br_pc4   = 32'h0000_0100;
        br_imm16 = 16'h0010;
        tick();
        check("brst_addr",  imem_addr,  32'h140);
        check("brst_inst",  if_id_inst, 32'h0);
        check("brst_valid", {31'b0, if_id_valid}, 32'h0);
        br_taken = 1'b0;
        stall    = 1'b0;
        tick();
        check("brst_redir_addr", imem_addr,  32'h144);
        check("brst_redir_inst", if_id_inst, mem_word(32'h140));

        // branch to the last word, then wrap: 0 + (-1 << 2) = 0xFFFF_FFFC
        br_taken = 1'b1;
        br_pc4   = 32'h0;
        br_imm16 = 16'hFFFF;
        tick();
        check("wrap_tgt", imem_addr, 32'hFFFF_FFFC);
        br_taken = 1'b0;
        tick();
        check("wrap_addr", imem_addr,  32'h0);
        check("wrap_inst", if_id_inst, mem_word(32'hFFFF_FFFC));
        check("wrap_pc4",  if_id_pc4,  32'h0);
        tick();
        check("after_wrap_addr", imem_addr, 32'h4);

        // reset in the middle of a stall, with a branch also requested
        stall = 1'b1;
        tick();
        check("pre_rst_addr", imem_addr, 32'h4);
        reset    = 1'b1;
        br_taken = 1'b1;
        #1;
        check("stall_flush", {31'b0, id_flush}, 32'h1);
        tick();
        check("mid_rst_addr",  imem_addr,  32'h0);
        check("mid_rst_inst",  if_id_inst, 32'h0);
        check("mid_rst_pc4",   if_id_pc4,  32'h0);
        check("mid_rst_valid", {31'b0, if_id_valid}, 32'h0);
        check("mid_rst_flush", {31'b0, id_flush},    32'h0);
`ifdef IF_PERF_CNT_EN
        check("mid_rst_fcnt", fetch_cnt,  32'h0);
        check("mid_rst_bcnt", bubble_cnt, 32'h0);
`endif

        // 10 edges: boot, 2 fetches, 2 stalls, fetch, branch, 3 fetches
        reset    = 1'b0;
        br_taken = 1'b0;
        stall    = 1'b0;
        tick();
        tick();
        tick();
        stall = 1'b1;
        tick();
        tick();
        check("perf_stall_addr", imem_addr, 32'h8);
        stall = 1'b0;
        tick();
        br_taken = 1'b1;
        br_pc4   = 32'h0000_0040;
        br_imm16 = 16'h0000;
        tick();
        br_taken = 1'b0;
        tick();
        tick();
        tick();
        check("perf_addr", imem_addr,  32'h4C);
        check("perf_inst", if_id_inst, mem_word(32'h48));
`ifdef IF_PERF_CNT_EN
        check("perf_fcnt", fetch_cnt,  32'd6);
        check("perf_bcnt", bubble_cnt, 32'd3);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
